// File: rtl/mem_stage.sv
// MEM pipeline stage: word-addressed data memory, branch resolve, MEM/WB boundary registers.
// Optional MEM_STATS_EN adds saturating accepted-load/store counters (oLoadCount, oStoreCount).
module mem_stage #(
    parameter int MEM_WORDS = 256,
    parameter int AW        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iStall,
    input  logic        iRegWrite,
    input  logic        iMemToReg,
    input  logic        iMemWrite,
    input  logic        iMemRead,
    input  logic        iMemBranch,
    input  logic [31:0] iBranchResult,
    input  logic        iZFlag,
    input  logic [31:0] iAluRes,
    input  logic [31:0] iData2,
    input  logic [4:0]  iRegDestMux,
    output logic        oPCSrc,
    output logic [31:0] oBranchTarget,
    output logic        oRegWrite,
    output logic        oMemToReg,
    output logic [31:0] oReadData,
    output logic [31:0] oAluRes,
    output logic [4:0]  oRegDestMux,
    output logic [31:0] oWriteData,
    output logic        oMisalign
`ifdef MEM_STATS_EN
    ,
    output logic [15:0] oLoadCount,
    output logic [15:0] oStoreCount
`endif
);

    // Zero-initialised so loads from never-written words return 0 rather than X.
    logic [31:0] mem [MEM_WORDS] = '{default: 32'h0};

    logic [AW-1:0] idx;
    logic          aligned;
    logic          advance;
    logic          load_en;
    logic          store_en;
    logic          misalign_hit;

    logic        reg_write_q,  reg_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic [31:0] read_data_q,  read_data_d;
    logic [31:0] alu_res_q,    alu_res_d;
    logic [4:0]  reg_dest_q,   reg_dest_d;
    logic        misalign_q,   misalign_d;

    assign idx          = iAluRes[AW+1:2];
    assign aligned      = (iAluRes[1:0] == 2'b00);
    assign advance      = ~iStall;
    assign load_en      = advance & iMemRead & aligned;
    assign store_en     = advance & iMemWrite & aligned;
    assign misalign_hit = advance & (iMemRead | iMemWrite) & ~aligned;

    always_comb begin
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        read_data_d  = read_data_q;
        alu_res_d    = alu_res_q;
        reg_dest_d   = reg_dest_q;
        misalign_d   = misalign_q | misalign_hit;
        if (advance) begin
            reg_write_d  = iRegWrite;
            mem_to_reg_d = iMemToReg;
            read_data_d  = load_en ? mem[idx] : 32'h0;
            alu_res_d    = iAluRes;
            reg_dest_d   = iRegDestMux;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            read_data_q  <= 32'h0;
            alu_res_q    <= 32'h0;
            reg_dest_q   <= 5'd0;
            misalign_q   <= 1'b0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            read_data_q  <= read_data_d;
            alu_res_q    <= alu_res_d;
            reg_dest_q   <= reg_dest_d;
            misalign_q   <= misalign_d;
        end
    end

    // Memory contents survive reset; only the store issued during reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && store_en) begin
            mem[idx] <= iData2;
        end
    end

`ifdef MEM_STATS_EN
    logic [15:0] load_cnt_q,  load_cnt_d;
    logic [15:0] store_cnt_q, store_cnt_d;

    always_comb begin
        load_cnt_d  = load_cnt_q;
        store_cnt_d = store_cnt_q;
        if (load_en && load_cnt_q != 16'hFFFF) begin
            load_cnt_d = load_cnt_q + 16'd1;
        end
        if (store_en && store_cnt_q != 16'hFFFF) begin
            store_cnt_d = store_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt_q  <= 16'd0;
            store_cnt_q <= 16'd0;
        end else begin
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    assign oLoadCount  = load_cnt_q;
    assign oStoreCount = store_cnt_q;
`endif

    assign oPCSrc        = iMemBranch & iZFlag & ~iStall;
    assign oBranchTarget = iBranchResult;
    assign oRegWrite     = reg_write_q;
    assign oMemToReg     = mem_to_reg_q;
    assign oReadData     = read_data_q;
    assign oAluRes       = alu_res_q;
    assign oRegDestMux   = reg_dest_q;
    assign oWriteData    = mem_to_reg_q ? read_data_q : alu_res_q;
    assign oMisalign     = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a reference model predicts the MEM/WB registers for each
// driven instruction, pushes the prediction, and pops/compares it one clock later.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst, iStall, iRegWrite, iMemToReg, iMemWrite, iMemRead, iMemBranch, iZFlag;
    logic [31:0] iBranchResult, iAluRes, iData2;
    logic [4:0]  iRegDestMux;
    logic        oPCSrc, oRegWrite, oMemToReg, oMisalign;
    logic [31:0] oBranchTarget, oReadData, oAluRes, oWriteData;
    logic [4:0]  oRegDestMux;
`ifdef MEM_STATS_EN
    logic [15:0] oLoadCount, oStoreCount;
`endif

    always #5 clk = ~clk;

    mem_stage #(.MEM_WORDS(256), .AW(8)) dut (
        .clk(clk), .rst(rst), .iStall(iStall), .iRegWrite(iRegWrite), .iMemToReg(iMemToReg),
        .iMemWrite(iMemWrite), .iMemRead(iMemRead), .iMemBranch(iMemBranch),
        .iBranchResult(iBranchResult), .iZFlag(iZFlag), .iAluRes(iAluRes), .iData2(iData2),
        .iRegDestMux(iRegDestMux), .oPCSrc(oPCSrc), .oBranchTarget(oBranchTarget),
        .oRegWrite(oRegWrite), .oMemToReg(oMemToReg), .oReadData(oReadData), .oAluRes(oAluRes),
        .oRegDestMux(oRegDestMux), .oWriteData(oWriteData), .oMisalign(oMisalign)
`ifdef MEM_STATS_EN
        , .oLoadCount(oLoadCount), .oStoreCount(oStoreCount)
`endif
    );

    typedef struct {
        logic [31:0] rd;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rdst;
        logic        rw;
        logic        m2r;
        logic        mis;
        logic [15:0] lc;
        logic [15:0] sc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mdl;
    logic [31:0] ref_mem [256];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_txn = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One instruction: drive after negedge, check combinational branch outputs, model the
    // clock edge, then compare the registered outputs just after the posedge.
    task automatic step(input logic r, input logic st, input logic mw, input logic mr,
                        input logic rw, input logic m2r, input logic [31:0] alu,
                        input logic [31:0] data, input logic [4:0] rd,
                        input logic br, input logic z, input logic [31:0] tgt);
        exp_t       e;
        logic       al;
        logic [7:0] idx;
        @(negedge clk);
        rst = r; iStall = st; iMemWrite = mw; iMemRead = mr; iRegWrite = rw; iMemToReg = m2r;
        iAluRes = alu; iData2 = data; iRegDestMux = rd;
        iMemBranch = br; iZFlag = z; iBranchResult = tgt;
        #1;
        check("pcsrc", {31'd0, oPCSrc}, {31'd0, br & z & ~st});
        check("btarget", oBranchTarget, tgt);

        al  = (alu[1:0] == 2'b00);
        idx = alu[9:2];
        if (r) begin
            mdl = '{default: '0};
        end else if (!st) begin
            mdl.rd = (mr && al) ? ref_mem[idx] : 32'h0;
            if (mr && al && mdl.lc != 16'hFFFF) mdl.lc++;
            if (mw && al && mdl.sc != 16'hFFFF) mdl.sc++;
            if (mw && al) ref_mem[idx] = data;
            if ((mr || mw) && !al) mdl.mis = 1'b1;
            mdl.alu  = alu;
            mdl.rdst = rd;
            mdl.rw   = rw;
            mdl.m2r  = m2r;
        end
        mdl.wd = mdl.m2r ? mdl.rd : mdl.alu;
        sb.push_back(mdl);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_txn++;
        check("readdata", oReadData, e.rd);
        check("alures", oAluRes, e.alu);
        check("writedata", oWriteData, e.wd);
        check("regdest", {27'd0, oRegDestMux}, {27'd0, e.rdst});
        check("regwrite", {31'd0, oRegWrite}, {31'd0, e.rw});
        check("memtoreg", {31'd0, oMemToReg}, {31'd0, e.m2r});
        check("misalign", {31'd0, oMisalign}, {31'd0, e.mis});
`ifdef MEM_STATS_EN
        check("loadcnt", {16'd0, oLoadCount}, {16'd0, e.lc});
        check("storecnt", {16'd0, oStoreCount}, {16'd0, e.sc});
`endif
        $display("txn %0d rst=%0b stall=%0b we=%0b re=%0b addr=%h rdata=%h wdata=%h mis=%0b",
                 n_txn, r, st, mw, mr, alu, oReadData, oWriteData, oMisalign);
    endtask

    // Plain ALU instruction with no memory access and no branch.
    task automatic nop(input logic [31:0] alu);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, alu, 32'h0, 5'd3, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        mdl = '{default: '0};
        rst = 1'b1; iStall = 1'b0; iRegWrite = 1'b0; iMemToReg = 1'b0; iMemWrite = 1'b0;
        iMemRead = 1'b0; iMemBranch = 1'b0; iZFlag = 1'b0; iBranchResult = 32'h0;
        iAluRes = 32'h0; iData2 = 32'h0; iRegDestMux = 5'd0;

        // Reset with random inputs for two cycles; any store during reset is dropped.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom & 32'hFFFF_FFFC, $urandom, 5'($urandom), 1'b0, 1'b0, 32'h0);
        end

        // Store then load back through the WB mux.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 32'h0, 5'd7, 1'b0, 1'b0, 32'h0);

        // Address wrap: 0x400 aliases word 0.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h400, 32'h12345678, 5'd0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 5'd8, 1'b0, 1'b0, 32'h0);

        // Misaligned store is suppressed and sets the sticky flag.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h13, 32'hFFFFFFFF, 5'd0, 1'b0, 1'b0, 32'h0);
        nop(32'h55);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 32'h0, 5'd9, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);

        // Stalled store with new controls: nothing moves, the word stays 0.
        nop(32'h77);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 5'd31, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h0, 5'd10, 1'b0, 1'b0, 32'h0);

        // Branch resolve, including a stalled branch.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1, 32'h40);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 32'h40);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1, 32'h80);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1, 32'h80);

        // Mixed random traffic over a small address window, occasionally misaligned or stalled.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic        w;
            a = {$urandom_range(0, 31), 2'b00};
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
            w = 1'($urandom);
            step(1'b0, ($urandom_range(0, 4) == 0), w, ~w & 1'($urandom), 1'($urandom),
                 1'($urandom), a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), $urandom);
        end

        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
